wb_pipe: RTL and testbench

- Parametrised successor to the single-cycle writeback select.
- Selects the result from NSRC source buses, registers it in a one-entry writeback pipeline register with a valid/ready handshake, and drives the register-file write port.
- Also provides flush handling, halt detection with a halted state, a retired-instruction counter, a sticky select-error flag and an optional forwarding tap.
- Sits between the memory stage and the register file.

---
 rtl/wb_pkg.sv | 18 +
 rtl/wb_src_mux.sv | 22 ++
 rtl/wb_pipe.sv | 116 +++++++++++
 tb/tb_wb_pipe.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the writeback stage: source indices, FSM state type and
// default widths.
package wb_pkg;

  localparam int RS_PC   = 0;
  localparam int RS_MEM  = 1;
  localparam int RS_ALU  = 2;
  localparam int RS_SPEC = 3;

  localparam int WB_DATA_W = 16;
  localparam int WB_RA_W   = 3;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } wb_state_e;

endpackage

// File: rtl/wb_src_mux.sv
// NSRC:1 result-source mux. An index at or above NSRC selects zero and raises
// out_of_range.
module wb_src_mux #(
  parameter int DATA_W = 16,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2
) (
  input  logic [NSRC*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       sel,
  output logic [DATA_W-1:0]      sel_data,
  output logic                   out_of_range
);

  always_comb begin
    sel_data     = '0;
    out_of_range = (int'(sel) >= NSRC);
    for (int k = 0; k < NSRC; k++) begin
      if (sel == SEL_W'(k)) sel_data = in_data[k*DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/wb_pipe.sv
// Writeback stage: source select, one-entry valid/ready register, halt FSM,
// retire counter and sticky select error. Define WB_FWD_EN to drive the fwd_* tap.
module wb_pipe
  import wb_pkg::*;
#(
  parameter int DATA_W = WB_DATA_W,
  parameter int NSRC   = 4,
  parameter int SEL_W  = 2,
  parameter int RA_W   = WB_RA_W,
  parameter int CNT_W  = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NSRC*DATA_W-1:0] in_data,
  input  logic [SEL_W-1:0]       in_sel,
  input  logic                   in_wr_en,
  input  logic [RA_W-1:0]        in_wr_addr,
  input  logic                   in_halt,
  input  logic                   flush,
  output logic                   rf_we,
  output logic [RA_W-1:0]        rf_waddr,
  output logic [DATA_W-1:0]      rf_wdata,
  output logic                   halted,
  output logic [CNT_W-1:0]       retire_cnt,
  output logic                   sel_err,
  output logic                   fwd_valid,
  output logic [RA_W-1:0]        fwd_addr,
  output logic [DATA_W-1:0]      fwd_data
);

  wb_state_e          state_q, state_d;
  logic               valid_q, valid_d;
  logic               we_q, we_d;
  logic [RA_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]  wdata_q, wdata_d;
  logic [CNT_W-1:0]   retire_cnt_q, retire_cnt_d;
  logic               sel_err_q, sel_err_d;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_oor;
  logic               xfer;

  wb_src_mux #(
    .DATA_W(DATA_W),
    .NSRC  (NSRC),
    .SEL_W (SEL_W)
  ) u_src_mux (
    .in_data     (in_data),
    .sel         (in_sel),
    .sel_data    (sel_data),
    .out_of_range(sel_oor)
  );

  assign in_ready = (state_q == RUN) && !rst;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    valid_d      = 1'b0;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    sel_err_d    = sel_err_q;
    retire_cnt_d = retire_cnt_q;
    if (valid_q) retire_cnt_d = retire_cnt_q + CNT_W'(1);
    if (xfer) begin
      // A flushed transfer still loads the data registers; only valid is killed.
      valid_d = !flush;
      wdata_d = sel_data;
      addr_d  = in_wr_addr;
      we_d    = in_wr_en && !in_halt;
      if (sel_oor) sel_err_d = 1'b1;
      if (in_halt && !flush) state_d = HALTED;
    end
  end

  // Writeback register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= RUN;
      valid_q      <= 1'b0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      retire_cnt_q <= '0;
      sel_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      valid_q      <= valid_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      retire_cnt_q <= retire_cnt_d;
      sel_err_q    <= sel_err_d;
    end
  end

  assign rf_we      = valid_q && we_q;
  assign rf_waddr   = addr_q;
  assign rf_wdata   = wdata_q;
  assign halted     = (state_q == HALTED);
  assign retire_cnt = retire_cnt_q;
  assign sel_err    = sel_err_q;

`ifdef WB_FWD_EN
  assign fwd_valid = valid_q && we_q;
  assign fwd_addr  = addr_q;
  assign fwd_data  = wdata_q;
`else
  assign fwd_valid = 1'b0;
  assign fwd_addr  = '0;
  assign fwd_data  = '0;
`endif

endmodule

// File: tb/tb_wb_pipe.sv
// Bench for wb_pipe: a 4-source/16-bit-counter instance and a 3-source/4-bit-counter
// instance share stimulus and are checked against a behavioural model.
module tb_wb_pipe;

  localparam int DW = 16;
  localparam int AW = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst, in_valid, in_wr_en, in_halt, flush;
  logic [1:0]    in_sel;
  logic [AW-1:0] in_wr_addr;
  logic [4*DW-1:0] in_data;

  logic          in_ready_a, rf_we_a, halted_a, sel_err_a, fwd_valid_a;
  logic [AW-1:0] rf_waddr_a, fwd_addr_a;
  logic [DW-1:0] rf_wdata_a, fwd_data_a;
  logic [15:0]   retire_cnt_a;

  logic          in_ready_b, rf_we_b, halted_b, sel_err_b, fwd_valid_b;
  logic [AW-1:0] rf_waddr_b, fwd_addr_b;
  logic [DW-1:0] rf_wdata_b, fwd_data_b;
  logic [3:0]    retire_cnt_b;

  wb_pipe #(.DATA_W(DW), .NSRC(4), .SEL_W(2), .RA_W(AW), .CNT_W(16)) dut_a (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
    .in_data(in_data), .in_sel(in_sel), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
    .in_halt(in_halt), .flush(flush), .rf_we(rf_we_a), .rf_waddr(rf_waddr_a),
    .rf_wdata(rf_wdata_a), .halted(halted_a), .retire_cnt(retire_cnt_a),
    .sel_err(sel_err_a), .fwd_valid(fwd_valid_a), .fwd_addr(fwd_addr_a), .fwd_data(fwd_data_a)
  );

  wb_pipe #(.DATA_W(DW), .NSRC(3), .SEL_W(2), .RA_W(AW), .CNT_W(4)) dut_b (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_data(in_data[3*DW-1:0]), .in_sel(in_sel), .in_wr_en(in_wr_en), .in_wr_addr(in_wr_addr),
    .in_halt(in_halt), .flush(flush), .rf_we(rf_we_b), .rf_waddr(rf_waddr_b),
    .rf_wdata(rf_wdata_b), .halted(halted_b), .retire_cnt(retire_cnt_b),
    .sel_err(sel_err_b), .fwd_valid(fwd_valid_b), .fwd_addr(fwd_addr_b), .fwd_data(fwd_data_b)
  );

  int checks = 0;
  int errors = 0;

  // Reference model, one entry per instance.
  int            m_ns   [2] = '{4, 3};
  int            m_mod  [2] = '{65536, 16};
  bit            m_halted [2];
  bit            m_vld  [2];
  bit            m_we   [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  int            m_cnt  [2];
  bit            m_err  [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        m_halted[i] = 0; m_vld[i] = 0; m_we[i] = 0;
        m_addr[i] = '0; m_data[i] = '0; m_cnt[i] = 0; m_err[i] = 0;
      end else begin
        if (m_vld[i]) m_cnt[i] = (m_cnt[i] + 1) % m_mod[i];
        if (in_valid && !m_halted[i]) begin
          m_vld[i]  = !flush;
          m_addr[i] = in_wr_addr;
          m_we[i]   = in_wr_en && !in_halt;
          if (int'(in_sel) < m_ns[i]) m_data[i] = in_data[in_sel*DW +: DW];
          else begin
            m_data[i] = '0;
            m_err[i]  = 1;
          end
          if (in_halt && !flush) m_halted[i] = 1;
        end else begin
          m_vld[i] = 0;
        end
      end
    end
  endtask

  task automatic check_ready();
    check("a.in_ready", in_ready_a, !m_halted[0] && !rst);
    check("b.in_ready", in_ready_b, !m_halted[1] && !rst);
  endtask

  task automatic check_outs();
    bit ew [2];
    for (int i = 0; i < 2; i++) ew[i] = m_vld[i] && m_we[i];
    check("a.rf_we", rf_we_a, ew[0]);
    check("a.rf_waddr", rf_waddr_a, m_addr[0]);
    check("a.rf_wdata", rf_wdata_a, m_data[0]);
    check("a.halted", halted_a, m_halted[0]);
    check("a.retire_cnt", retire_cnt_a, m_cnt[0]);
    check("a.sel_err", sel_err_a, m_err[0]);
    check("b.rf_we", rf_we_b, ew[1]);
    check("b.rf_waddr", rf_waddr_b, m_addr[1]);
    check("b.rf_wdata", rf_wdata_b, m_data[1]);
    check("b.halted", halted_b, m_halted[1]);
    check("b.retire_cnt", retire_cnt_b, m_cnt[1]);
    check("b.sel_err", sel_err_b, m_err[1]);
`ifdef WB_FWD_EN
    check("a.fwd_valid", fwd_valid_a, ew[0]);
    check("a.fwd_addr", fwd_addr_a, m_addr[0]);
    check("a.fwd_data", fwd_data_a, rf_wdata_a);
    check("b.fwd_data", fwd_data_b, m_data[1]);
`else
    check("a.fwd_valid", fwd_valid_a, 0);
    check("a.fwd_addr", fwd_addr_a, 0);
    check("a.fwd_data", fwd_data_a, 0);
    check("b.fwd_data", fwd_data_b, 0);
`endif
  endtask

  task automatic step(input logic r, input logic v, input logic [1:0] s, input logic we,
                      input logic [AW-1:0] a, input logic h, input logic f);
    @(negedge clk);
    rst = r; in_valid = v; in_sel = s; in_wr_en = we; in_wr_addr = a; in_halt = h; flush = f;
    #1;
    check_ready();
    @(posedge clk);
    model_edge();
    #1;
    check_outs();
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_sel = '0; in_wr_en = 1'b0;
    in_wr_addr = '0; in_halt = 1'b0; flush = 1'b0;
    in_data = {16'h00FF, 16'h1234, 16'hBEEF, 16'h0002};

    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 1, 2, 1, 5, 0, 0);
    check("rst.retire_cnt", retire_cnt_a, 0);
    check("rst.rf_we", rf_we_a, 0);

    step(0, 1, 2, 1, 5, 0, 0);
    check("alu.rf_we", rf_we_a, 1);
    check("alu.rf_waddr", rf_waddr_a, 5);
    check("alu.rf_wdata", rf_wdata_a, 16'h1234);

    step(0, 1, 0, 1, 1, 0, 0);
    check("b2b.pc", rf_wdata_a, 16'h0002);
    check("alu.retire_cnt", retire_cnt_a, 1);
    step(0, 1, 1, 1, 2, 0, 0);
    check("b2b.mem", rf_wdata_a, 16'hBEEF);
    step(0, 1, 3, 1, 3, 0, 0);
    check("b2b.spec", rf_wdata_a, 16'h00FF);
    check("oor.rf_wdata", rf_wdata_b, 0);
    check("oor.sel_err", sel_err_b, 1);
    step(0, 1, 1, 1, 4, 0, 0);
    check("oor.sticky", sel_err_b, 1);
    step(0, 0, 0, 0, 0, 0, 0);
    check("b2b.retire_cnt", retire_cnt_a, 5);

    step(0, 1, 2, 1, 6, 0, 1);
    check("flush.rf_we", rf_we_a, 0);
    step(0, 1, 2, 1, 7, 1, 1);
    check("flush.cnt", retire_cnt_a, 5);
    check("halt_flush.halted", halted_a, 0);

    step(0, 1, 2, 1, 4, 0, 0);
    step(0, 0, 0, 0, 0, 0, 1);
    step(0, 1, 2, 1, 1, 1, 0);
    check("halt.halted", halted_a, 1);
    check("halt.rf_we", rf_we_a, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 2, 1, 2, 0, 1);
    check("halt.ignored_cnt", retire_cnt_a, 7);
    check("halt.ready", in_ready_a, 0);
    step(1, 1, 2, 1, 2, 0, 0);
    check("rst.halted", halted_a, 0);

    for (int i = 0; i < 16; i++) begin
      in_data = {$urandom, $urandom};
      step(0, 1, 2'($urandom_range(0, 2)), 1'($urandom), 3'($urandom), 0, 0);
    end
    step(0, 0, 0, 0, 0, 0, 0);
    check("wrap.cnt_b", retire_cnt_b, 0);
    check("wrap.cnt_a", retire_cnt_a, 16);

    for (int i = 0; i < 400; i++) begin
      in_data = {$urandom, $urandom};
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 3) != 0), 2'($urandom),
           1'($urandom), 3'($urandom), ($urandom_range(0, 15) == 0), ($urandom_range(0, 7) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
